// File: rtl/twd_mul_stage.sv
// Radix-8 twiddle multiplier for one FFT stage: LANES complex samples per beat, 3 register stages.
// Optional macro TWD_MUL_STAGE_ROUND_EN adds round-half-up before the final >>>8.
module twd_mul_stage #(
   parameter int WIDTH         = 9,
   parameter int LANES         = 16,
   parameter int BEATS_PER_TWD = 4,
   parameter int STRIDE        = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_valid,
   input  logic                    i_sof,
   input  logic signed [WIDTH+1:0] i_re [0:LANES-1],
   input  logic signed [WIDTH+1:0] i_im [0:LANES-1],
   output logic                    o_valid,
   output logic signed [WIDTH+3:0] o_re [0:LANES-1],
   output logic signed [WIDTH+3:0] o_im [0:LANES-1],
   output logic [2:0]              o_twd_k
);

   localparam int IW     = WIDTH + 2;
   localparam int PW     = WIDTH + 12;
   localparam int SW     = WIDTH + 13;
   localparam int OW     = WIDTH + 4;
   localparam int CNT_N  = 8 * BEATS_PER_TWD;
   localparam int CNT_W  = $clog2(CNT_N);
   localparam int IDX_SH = $clog2(BEATS_PER_TWD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_N - 1);

`ifdef TWD_MUL_STAGE_ROUND_EN
   localparam logic signed [SW-1:0] RND = SW'(128);
`else
   localparam logic signed [SW-1:0] RND = '0;
`endif

   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] cur_cnt;
   logic [2:0]       idx;
   logic [2:0]       twd_k;

   // A frame start forces this beat onto count 0; the stored count is then 1.
   always_comb begin
      cur_cnt = i_sof ? '0 : beat_cnt;
      idx     = 3'(cur_cnt >> IDX_SH);
      twd_k   = 3'(idx * 3'(STRIDE));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt <= '0;
      end else if (i_valid) begin
         beat_cnt <= (cur_cnt == CNT_LAST) ? '0 : cur_cnt + CNT_W'(1);
      end
   end

   // Stage 1: input samples, twiddle exponent, valid
   logic                 s1_valid;
   logic [2:0]           s1_k;
   logic signed [IW-1:0] s1_re [0:LANES-1];
   logic signed [IW-1:0] s1_im [0:LANES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_k     <= '0;
         for (int l = 0; l < LANES; l++) begin
            s1_re[l] <= '0;
            s1_im[l] <= '0;
         end
      end else begin
         s1_valid <= i_valid;
         s1_k     <= twd_k;
         for (int l = 0; l < LANES; l++) begin
            s1_re[l] <= i_re[l];
            s1_im[l] <= i_im[l];
         end
      end
   end

   // W8^k coefficients, Q2.8
   logic signed [9:0] coef_c;
   logic signed [9:0] coef_d;

   always_comb begin
      coef_c = '0;
      coef_d = '0;
      case (s1_k)
         3'd0: begin coef_c =  10'sd256; coef_d =  10'sd0;   end
         3'd1: begin coef_c =  10'sd181; coef_d = -10'sd181; end
         3'd2: begin coef_c =  10'sd0;   coef_d = -10'sd256; end
         3'd3: begin coef_c = -10'sd181; coef_d = -10'sd181; end
         3'd4: begin coef_c = -10'sd256; coef_d =  10'sd0;   end
         3'd5: begin coef_c = -10'sd181; coef_d =  10'sd181; end
         3'd6: begin coef_c =  10'sd0;   coef_d =  10'sd256; end
         3'd7: begin coef_c =  10'sd181; coef_d =  10'sd181; end
         default: begin coef_c = '0; coef_d = '0; end
      endcase
   end

   // Stage 2: the four partial products per lane
   logic                 s2_valid;
   logic [2:0]           s2_k;
   logic signed [PW-1:0] s2_ac [0:LANES-1];
   logic signed [PW-1:0] s2_bd [0:LANES-1];
   logic signed [PW-1:0] s2_ad [0:LANES-1];
   logic signed [PW-1:0] s2_bc [0:LANES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid <= 1'b0;
         s2_k     <= '0;
         for (int l = 0; l < LANES; l++) begin
            s2_ac[l] <= '0;
            s2_bd[l] <= '0;
            s2_ad[l] <= '0;
            s2_bc[l] <= '0;
         end
      end else begin
         s2_valid <= s1_valid;
         s2_k     <= s1_k;
         for (int l = 0; l < LANES; l++) begin
            s2_ac[l] <= PW'(s1_re[l]) * PW'(coef_c);
            s2_bd[l] <= PW'(s1_im[l]) * PW'(coef_d);
            s2_ad[l] <= PW'(s1_re[l]) * PW'(coef_d);
            s2_bc[l] <= PW'(s1_im[l]) * PW'(coef_c);
         end
      end
   end

   // Stage 3: combine, optional rounding, shift; the result magnitude always fits OW bits
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_valid <= 1'b0;
         o_twd_k <= '0;
         for (int l = 0; l < LANES; l++) begin
            o_re[l] <= '0;
            o_im[l] <= '0;
         end
      end else begin
         o_valid <= s2_valid;
         o_twd_k <= s2_k;
         for (int l = 0; l < LANES; l++) begin
            o_re[l] <= OW'((SW'(s2_ac[l]) - SW'(s2_bd[l]) + RND) >>> 8);
            o_im[l] <= OW'((SW'(s2_ad[l]) + SW'(s2_bc[l]) + RND) >>> 8);
         end
      end
   end

endmodule

// File: tb/tb_twd_mul_stage.sv
// Randomized bench for twd_mul_stage: stimulus tasks, a timestamped expected queue, final report.
module tb_twd_mul_stage;

  localparam int W     = 9;
  localparam int L     = 16;
  localparam int B     = 4;
  localparam int S     = 1;
  localparam int IW    = W + 2;
  localparam int OW    = W + 4;
  localparam int EXP_W = 35 + 2 * L * OW;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 i_valid;
  logic                 i_sof;
  logic signed [IW-1:0] i_re [0:L-1];
  logic signed [IW-1:0] i_im [0:L-1];
  logic                 o_valid;
  logic signed [OW-1:0] o_re [0:L-1];
  logic signed [OW-1:0] o_im [0:L-1];
  logic [2:0]           o_twd_k;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int mcnt     = 0;

  logic [EXP_W-1:0] exp_q[$];

  int c_tab [0:7] = '{256, 181, 0, -181, -256, -181, 0, 181};
  int d_tab [0:7] = '{0, -181, -256, -181, 0, 181, 256, 181};

  twd_mul_stage #(.WIDTH(W), .LANES(L), .BEATS_PER_TWD(B), .STRIDE(S)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .i_re    (i_re),
    .i_im    (i_im),
    .o_valid (o_valid),
    .o_re    (o_re),
    .o_im    (o_im),
    .o_twd_k (o_twd_k)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int want);
    checks = checks + 1;
    if (obs !== want) begin
      failures = failures + 1;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Exact product divided by 256 with floor, or round-half-up in the rounding build.
  function automatic int scale_q8(input int x);
    real r;
`ifdef TWD_MUL_STAGE_ROUND_EN
    r = (real'(x) + 128.0) / 256.0;
`else
    r = real'(x) / 256.0;
`endif
    return $rtoi($floor(r));
  endfunction

  function automatic logic [EXP_W-1:0] make_exp(input int use_cnt, input int due);
    logic [EXP_W-1:0] e;
    int k, c, d, a, b;
    k = ((use_cnt / B) * S) % 8;
    c = c_tab[k];
    d = d_tab[k];
    e = '0;
    e[31:0]  = due;
    e[34:32] = k[2:0];
    for (int l = 0; l < L; l++) begin
      a = int'(i_re[l]);
      b = int'(i_im[l]);
      e[35 + l * OW +: OW]       = OW'(scale_q8(a * c - b * d));
      e[35 + (L + l) * OW +: OW] = OW'(scale_q8(a * d + b * c));
    end
    return e;
  endfunction

  // Reference: every accepted beat is due at the output after its third register edge.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        exp_q.delete();
        mcnt = 0;
      end else if (clk) begin
        cycle = cycle + 1;
        if (i_valid) begin
          int use_cnt;
          use_cnt = i_sof ? 0 : mcnt;
          exp_q.push_back(make_exp(use_cnt, cycle + 2));
          mcnt = (use_cnt + 1) % (8 * B);
        end
      end
    end
  end

  // Scoreboard: compare on the falling edge, away from the capture edge.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_valid", int'(o_valid), 0);
        check("rst_k", int'(o_twd_k), 0);
        for (int l = 0; l < L; l++) begin
          check($sformatf("rst_re%0d", l), int'(o_re[l]), 0);
          check($sformatf("rst_im%0d", l), int'(o_im[l]), 0);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == cycle) begin
        e = exp_q.pop_front();
        check("out_valid", int'(o_valid), 1);
        check("twd_k", int'(o_twd_k), int'(e[34:32]));
        for (int l = 0; l < L; l++) begin
          check($sformatf("re%0d", l), int'(o_re[l]), int'($signed(e[35 + l * OW +: OW])));
          check($sformatf("im%0d", l), int'(o_im[l]), int'($signed(e[35 + (L + l) * OW +: OW])));
        end
      end else begin
        check("idle_valid", int'(o_valid), 0);
      end
    end
  end

  task automatic set_data(input bit rnd, input int a, input int b);
    int ra, rb;
    for (int l = 0; l < L; l++) begin
      ra = rnd ? int'($urandom_range(0, 2047)) - 1024 : a;
      rb = rnd ? int'($urandom_range(0, 2047)) - 1024 : b;
      i_re[l] = IW'(ra);
      i_im[l] = IW'(rb);
    end
  endtask

  task automatic beat(input bit v, input bit sof, input bit rnd, input int a, input int b);
    @(negedge clk);
    i_valid = v;
    i_sof   = sof;
    set_data(rnd, a, b);
  endtask

  initial begin
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    set_data(1'b0, 0, 0);

    // inputs toggle while held in reset
    for (int i = 0; i < 5; i++) beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 0, 0);
    beat(1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #2 rstn = 1'b1;

    // first beat after reset without sof still starts at k=0
    beat(1'b1, 1'b0, 1'b1, 0, 0);
    beat(1'b0, 1'b0, 1'b0, 0, 0);

    // k0 for four beats, then k1 on the fifth
    beat(1'b1, 1'b1, 1'b0, 100, 50);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0, 100, 50);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 1'b0, 0, 0);

    // full index sweep with extreme operands, wrapping past beat 32
    beat(1'b1, 1'b1, 1'b0, -1024, 1023);
    for (int i = 1; i < 40; i++) beat(1'b1, 1'b0, 1'b0, -1024, 1023);

    // valid gaps 1,0,0,1,1
    beat(1'b1, 1'b0, 1'b1, 0, 0);
    beat(1'b0, 1'b0, 1'b1, 0, 0);
    beat(1'b0, 1'b0, 1'b1, 0, 0);
    beat(1'b1, 1'b0, 1'b1, 0, 0);
    beat(1'b1, 1'b0, 1'b1, 0, 0);

    // resync at beat_cnt 13, then sof without valid, then back-to-back sof
    beat(1'b1, 1'b1, 1'b1, 0, 0);
    for (int i = 1; i < 13; i++) beat(1'b1, 1'b0, 1'b1, 0, 0);
    beat(1'b1, 1'b1, 1'b1, 0, 0);
    beat(1'b1, 1'b0, 1'b1, 0, 0);
    beat(1'b0, 1'b1, 1'b1, 0, 0);
    beat(1'b1, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b1, 0, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      beat(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 1'b1, 0, 0);

    // asynchronous reset with beats in flight
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1, 0, 0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("async_valid_drop", int'(o_valid), 0);
    #4 rstn = 1'b1;
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, 1'b1, 0, 0);

    // drain
    for (int i = 0; i < 6; i++) beat(1'b0, 1'b0, 1'b0, 0, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
